// File: rtl/op_sequencer_pkg.sv
// rtl/op_sequencer_pkg.sv - shared control definitions for the opcode sequencer
// State encodings, ALU op codes and opcode field offsets used by the sequencer.
package op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  typedef enum logic [3:0] {
    ALU_LOAD_A = 4'b1001,
    ALU_LOAD_B = 4'b1011,
    ALU_LOAD_C = 4'b1100,
    ALU_HALT   = 4'b1111
  } alu_op_e;

  localparam int ALU_LSB    = 0;
  localparam int REGOUT_LSB = 4;
  localparam int M5_LSB     = 6;

  // ALU op 0000 with both RegOut bits set: nothing in the datapath is written.
  localparam logic [11:0] IDLE_OP_DEFAULT =
    (12'h0 << M5_LSB) | (12'h3 << REGOUT_LSB) | (12'h0 << ALU_LSB);

  function automatic logic is_halt(input logic [3:0] alu);
    return alu == ALU_HALT;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - program store: one synchronous write port, one combinational read port
// Writes are dropped while a run is in progress.
module seq_prog_mem #(
  parameter int AW  = 4,
  parameter int OPW = 12
) (
  input  logic           clk,
  input  logic           we,
  input  logic           busy,
  input  logic [AW-1:0]  wr_addr,
  input  logic [OPW-1:0] wr_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [OPW-1:0] rd_data
);

  logic [OPW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - issues a stored opcode program, each step held HOLD cycles
// Optional repeat-run support is enabled by defining SEQ_LOOP_EN (adds loop_cnt input).
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int             AW      = 4,
  parameter int             OPW     = 12,
  parameter int             HOLD    = 2,
  parameter logic [OPW-1:0] IDLE_OP = IDLE_OP_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_addr,
  input  logic [OPW-1:0] prog_data,
  input  logic [AW-1:0]  last_addr,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]     loop_cnt,
`endif
  input  logic           start,
  input  logic           stop,
  output logic [OPW-1:0] opcode,
  output logic           busy,
  output logic           done,
  output logic           prog_err,
  output logic [AW-1:0]  pc
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  seq_state_e     state;
  logic [AW-1:0]  last_q;
  logic [HW-1:0]  hold_cnt;
  logic [AW-1:0]  rd_addr;
  logic [OPW-1:0] rd_data;
  logic           loop_again;
  logic           rd_halt;

`ifdef SEQ_LOOP_EN
  logic [7:0] loop_rem;
  assign loop_again = (pc == last_q) && (loop_rem != 8'd0);
`else
  assign loop_again = 1'b0;
`endif

  assign rd_halt = is_halt(rd_data[ALU_LSB +: 4]);

  // The single read port looks ahead at the step that would be loaded next.
  always_comb begin
    rd_addr = '0;
    if (state == ST_ISSUE && !loop_again) begin
      rd_addr = pc + AW'(1);
    end
  end

  seq_prog_mem #(
    .AW  (AW),
    .OPW (OPW)
  ) u_prog_mem (
    .clk     (clk),
    .we      (prog_we),
    .busy    (busy),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      opcode   <= IDLE_OP;
      busy     <= 1'b0;
      done     <= 1'b0;
      prog_err <= 1'b0;
      pc       <= '0;
      hold_cnt <= '0;
      last_q   <= '0;
`ifdef SEQ_LOOP_EN
      loop_rem <= 8'd0;
`endif
    end else begin
      prog_err <= prog_we & busy;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            last_q   <= last_addr;
            pc       <= '0;
            hold_cnt <= HW'(HOLD - 1);
`ifdef SEQ_LOOP_EN
            loop_rem <= loop_cnt;
`endif
            if (rd_halt) begin
              state  <= ST_DONE;
              opcode <= IDLE_OP;
              done   <= 1'b1;
            end else begin
              state  <= ST_ISSUE;
              opcode <= rd_data;
              busy   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (stop) begin
            state  <= ST_IDLE;
            opcode <= IDLE_OP;
            busy   <= 1'b0;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else if (pc == last_q && !loop_again) begin
            state  <= ST_DONE;
            opcode <= IDLE_OP;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            hold_cnt <= HW'(HOLD - 1);
            if (loop_again) begin
              pc <= '0;
`ifdef SEQ_LOOP_EN
              loop_rem <= loop_rem - 8'd1;
`endif
            end else begin
              pc <= pc + AW'(1);
            end
            // A halt step ends the run in place of being driven.
            if (rd_halt) begin
              state  <= ST_DONE;
              opcode <= IDLE_OP;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              opcode <= rd_data;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          opcode <= IDLE_OP;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - randomized self-checking bench for op_sequencer
// Expected traces come from a step-list model of the program and run rules.
module tb_op_sequencer;

  localparam int          HOLD  = 2;
  localparam logic [11:0] IDLEV = 12'h030;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [3:0]  last_addr = '0;
  logic [7:0]  loop_cnt = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] opcode;
  logic        busy;
  logic        done;
  logic        prog_err;
  logic [3:0]  pc;

  logic [11:0] m [16];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .last_addr (last_addr),
`ifdef SEQ_LOOP_EN
    .loop_cnt  (loop_cnt),
`endif
    .start     (start),
    .stop      (stop),
    .opcode    (opcode),
    .busy      (busy),
    .done      (done),
    .prog_err  (prog_err),
    .pc        (pc)
  );

  function automatic bit halt_op(input logic [11:0] op);
    return op[3:0] == 4'hF;
  endfunction

  task automatic load(input int a, input logic [11:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    m[a] = d;
  endtask

  // Runs the program and compares every cycle against the model trace.
  // stop_at / wr_at (>=0) inject a stop or a write of 12'hFFF to mem[1] at that sample.
  task automatic run_check(input string name, input int last, input int loops,
                           input int stop_at, input int wr_at);
    logic [11:0] eop[$];
    logic        eb[$];
    logic        ed[$];
    int passes, busy_n, exp_pc;
    bit halted;
    logic [14:0] got, exp;
    passes = 1;
`ifdef SEQ_LOOP_EN
    passes = loops + 1;
`else
    if (loops > 0) $display("note: loop_cnt=%0d has no effect in this build", loops);
`endif
    halted = 0;
    exp_pc = last;
    for (int p = 0; p < passes && !halted; p++) begin
      for (int i = 0; i <= last; i++) begin
        if (halt_op(m[i])) begin
          halted = 1; exp_pc = i;
          break;
        end
        for (int h = 0; h < HOLD; h++) begin
          eop.push_back(m[i]); eb.push_back(1'b1); ed.push_back(1'b0);
        end
      end
    end
    busy_n = eop.size();
    eop.push_back(IDLEV); eb.push_back(1'b0); ed.push_back(1'b1);
    for (int k = 0; k < 2; k++) begin
      eop.push_back(IDLEV); eb.push_back(1'b0); ed.push_back(1'b0);
    end
    if (stop_at >= 0 && stop_at < busy_n) begin
      for (int k = stop_at + 1; k < eop.size(); k++) begin
        eop[k] = IDLEV; eb[k] = 1'b0; ed[k] = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b1; last_addr = 4'(last); loop_cnt = 8'(loops);
    @(negedge clk);
    start = 1'b0;
    for (int idx = 0; idx < eop.size(); idx++) begin
      got = {opcode, busy, done, prog_err};
      exp = {eop[idx], eb[idx], ed[idx], (wr_at >= 0 && idx == wr_at + 1)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: op/busy/done/err got %h/%b/%b/%b expected %h/%b/%b/%b",
                 name, idx, got[14:3], got[2], got[1], got[0],
                 exp[14:3], exp[2], exp[1], exp[0]);
      end
      stop = 1'b0; prog_we = 1'b0;
      if (idx == stop_at) stop = 1'b1;
      if (idx == wr_at) begin
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 12'hFFF;
      end
      @(negedge clk);
    end
    stop = 1'b0; prog_we = 1'b0;
    if (stop_at < 0) begin
      n_vec++;
      if (pc !== 4'(exp_pc)) begin
        n_err++;
        $display("FAIL %s final pc: got %0d expected %0d", name, pc, exp_pc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({opcode, busy, done, prog_err, pc} !== {IDLEV, 3'b000, 4'd0}) begin
      n_err++;
      $display("FAIL reset: op/busy/done/err/pc got %h/%b/%b/%b/%0d expected 030/0/0/0/0",
               opcode, busy, done, prog_err, pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load(0, 12'hB09); load(1, 12'hB0B); load(2, 12'h102);
    run_check("basic", 2, 0, -1, -1);
  endtask

  task automatic test_halt();
    load(0, 12'h5A3); load(1, 12'h00F); load(2, 12'h111); load(3, 12'h222);
    run_check("halt", 3, 0, -1, -1);
  endtask

  task automatic test_abort();
    load(0, 12'hB09); load(1, 12'hB0B); load(2, 12'h102); load(3, 12'h2C4);
    run_check("abort", 3, 0, HOLD, -1);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({opcode, busy, done} !== {IDLEV, 2'b00}) begin
        n_err++;
        $display("FAIL start_stop cycle %0d: op/busy/done got %h/%b/%b expected 030/0/0",
                 k, opcode, busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_busy();
    load(0, 12'hB09); load(1, 12'hB0B); load(2, 12'h102);
    run_check("write_busy", 2, 0, -1, 1);
    run_check("rerun_after_drop", 2, 0, -1, -1);
  endtask

  task automatic test_loop();
    load(0, 12'h7C1);
    run_check("loop", 0, 2, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) load(a, 12'($urandom));
      run_check($sformatf("random%0d", r), (r == 0) ? 15 : int'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), -1, -1);
    end
  endtask

  task automatic test_reset_mid_run();
    load(0, 12'hB09); load(1, 12'hB0B); load(2, 12'h102);
    @(negedge clk);
    start = 1'b1; last_addr = 4'd2; loop_cnt = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({opcode, busy, done, pc} !== {IDLEV, 2'b00, 4'd0}) begin
      n_err++;
      $display("FAIL reset_mid_run: op/busy/done/pc got %h/%b/%b/%0d expected 030/0/0/0",
               opcode, busy, done, pc);
    end
    run_check("after_reset", 2, 0, -1, -1);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) m[a] = '0;
    test_reset();
    test_basic();
    test_halt();
    test_abort();
    test_write_busy();
    test_loop();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
